// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer: walks a register-init ROM and issues one single-byte I2C register write per entry, with inline delays, NACK retry and done/error status
module i2c_init_sequencer #(
  parameter int unsigned TABLE_LEN = 64,
  parameter logic [7:0]  DEVICE_ID = 8'h78,
  parameter logic        ADDR_MODE = 1'b1,
  parameter int unsigned PWR_DLY   = 50000,
  parameter int unsigned DLY_UNIT  = 50000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  output logic [7:0]  lut_index,
  input  logic [23:0] lut_data,
  output logic        wrreg_req,
  output logic        rdreg_req,
  output logic [15:0] addr,
  output logic        addr_mode,
  output logic [7:0]  wrdata,
  output logic [7:0]  device_id,
  input  logic        RW_Done,
  input  logic        ack,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [7:0]  err_index
);
  typedef enum logic [3:0] {PWR_WAIT, FETCH, CHECK, REQ, WAIT_DONE, DELAY, NEXT, DONE, ERR} state_t;
  localparam logic [31:0] PWR_LAST  = PWR_DLY == 0 ? 32'd0 : 32'(PWR_DLY - 1);
  localparam logic [7:0]  IDX_LAST  = 8'(TABLE_LEN - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d, load;
  logic [2:0] retry_q, retry_d;
  logic [7:0] idx_q, idx_d, wrdata_q, wrdata_d, err_idx_q, err_idx_d;
  logic [15:0] addr_q, addr_d;
  logic done_q, done_d, err_q, err_d;
  assign load = 32'(lut_data[7:0]) * 32'(DLY_UNIT);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    retry_d = retry_q;
    idx_d = idx_q;
    addr_d = addr_q;
    wrdata_d = wrdata_q;
    done_d = done_q;
    err_d = err_q;
    err_idx_d = err_idx_q;
    case (state_q)
      PWR_WAIT: begin
        cnt_d = cnt_q == PWR_LAST ? '0 : cnt_q + 32'd1;
        state_d = cnt_q == PWR_LAST ? FETCH : PWR_WAIT;
      end
      FETCH: state_d = CHECK;
      CHECK: if (lut_data[23:8] == 16'hFFFF) begin
        cnt_d = load;
        state_d = load == '0 ? NEXT : DELAY;
      end else begin
        addr_d = ADDR_MODE ? lut_data[23:8] : {8'h00, lut_data[15:8]};
        wrdata_d = lut_data[7:0];
        state_d = REQ;
      end
      REQ: state_d = WAIT_DONE;
      WAIT_DONE: if (RW_Done) begin
        if (!ack) state_d = NEXT;
        else if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 3'd1;
          state_d = REQ;
        end else begin
          err_idx_d = idx_q;
          err_d = 1'b1;
          state_d = ERR;
        end
      end
      DELAY: begin
        cnt_d = cnt_q - 32'd1;
        state_d = cnt_q == 32'd1 ? NEXT : DELAY;
      end
      NEXT: begin
        retry_d = '0;
        done_d = idx_q == IDX_LAST;
        idx_d = idx_q == IDX_LAST ? idx_q : idx_q + 8'd1;
        state_d = idx_q == IDX_LAST ? DONE : FETCH;
      end
      DONE, ERR: if (start) begin
        done_d = 1'b0;
        err_d = 1'b0;
        idx_d = '0;
        cnt_d = '0;
        retry_d = '0;
        state_d = PWR_WAIT;
      end
      default: state_d = PWR_WAIT;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= PWR_WAIT;
      cnt_q <= '0;
      retry_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
      wrdata_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      retry_q <= retry_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      wrdata_q <= wrdata_d;
      done_q <= done_d;
      err_q <= err_d;
      err_idx_q <= err_idx_d;
    end
  end
  assign lut_index = idx_q;
  assign wrreg_req = state_q == REQ;
  assign rdreg_req = 1'b0;
  assign addr = addr_q;
  assign addr_mode = ADDR_MODE;
  assign wrdata = wrdata_q;
  assign device_id = DEVICE_ID;
  assign busy = !(state_q == DONE || state_q == ERR);
  assign init_done = done_q;
  assign init_err = err_q;
  assign err_index = err_idx_q;
endmodule

// File: tb/tb_i2c_init_sequencer.sv
// tb_i2c_init_sequencer: scoreboard bench with ROM, randomised controller responder and table-level reference model
module tb_i2c_init_sequencer;
  localparam int TL = 4, PD = 20, DU = 10, MR = 3;
  typedef struct {logic [15:0] a; logic [7:0] d; int gap;} exp_t;
  logic Clk = 1'b0, Rst = 1'b1, start = 1'b0, RW_Done = 1'b0, ack = 1'b0;
  logic [23:0] lut_data = '0;
  logic [7:0] lut_index, wrdata, device_id, err_index;
  logic [15:0] addr;
  logic wrreg_req, rdreg_req, addr_mode, busy, init_done, init_err;
  logic [23:0] rom [TL];
  int nacks [TL];
  int attempts [TL];
  exp_t exp_q [$];
  int checks = 0, errors = 0, cyc = 0, ref_cyc = 0, epoch = 0, exp_eidx = 0;
  bit exp_done = 1'b0, exp_err = 1'b0;
  i2c_init_sequencer #(.TABLE_LEN(TL), .DEVICE_ID(8'h78), .ADDR_MODE(1'b1), .PWR_DLY(PD), .DLY_UNIT(DU), .MAX_RETRY(MR)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .lut_index(lut_index), .lut_data(lut_data),
    .wrreg_req(wrreg_req), .rdreg_req(rdreg_req), .addr(addr), .addr_mode(addr_mode),
    .wrdata(wrdata), .device_id(device_id), .RW_Done(RW_Done), .ack(ack), .busy(busy),
    .init_done(init_done), .init_err(init_err), .err_index(err_index)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) lut_data <= rom[lut_index[1:0]];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // every request a run should produce, in order, with its cycle distance from the previous reference point
  task automatic build();
    int pre, n;
    epoch++;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err = 1'b0;
    exp_eidx = 0;
    foreach (attempts[i]) attempts[i] = 0;
    pre = PD + 2;
    for (int i = 0; i < TL; i++) begin
      if (rom[i][23:8] == 16'hFFFF) pre += int'(rom[i][7:0]) * DU + 3;
      else begin
        n = nacks[i] > MR ? MR + 1 : nacks[i] + 1;
        for (int k = 0; k < n; k++) exp_q.push_back('{rom[i][23:8], rom[i][7:0], k == 0 ? pre : 1});
        if (nacks[i] > MR) begin
          exp_err = 1'b1;
          exp_eidx = i;
          return;
        end
        pre = 4;
      end
    end
    exp_done = 1'b1;
  endtask
  always @(negedge Clk) if (!Rst && wrreg_req) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_req: got addr %0h data %0h expected no request (cycle %0d)", addr, wrdata, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("addr", addr, e.a);
      chk("wrdata", wrdata, e.d);
      chk("req_gap", cyc - ref_cyc, e.gap);
      chk("rdreg_req", rdreg_req, 0);
      chk("device_id", device_id, 8'h78);
      chk("addr_mode", addr_mode, 1);
    end
  end
  initial begin : responder
    int idx, ep, wait_n;
    logic [15:0] a;
    logic [7:0] d;
    wait_n = -1;
    forever begin
      @(negedge Clk);
      RW_Done = 1'b0;
      ack = 1'b0;
      if (wait_n > 0) wait_n--;
      else if (wait_n == 0) begin
        wait_n = -1;
        RW_Done = 1'b1;
        ack = attempts[idx] < nacks[idx];
        if (ep == epoch) begin
          attempts[idx]++;
          ref_cyc = cyc;
          chk("addr_hold", addr, a);
          chk("wrdata_hold", wrdata, d);
        end
      end
      if (!Rst && wrreg_req) begin
        idx = int'(lut_index[1:0]);
        ep = epoch;
        a = addr;
        d = wrdata;
        wait_n = $urandom_range(0, 3);
      end
    end
  end
  task automatic do_reset();
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_lut_index", lut_index, 0);
    chk("rst_wrreg_req", wrreg_req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_busy", busy, 1);
    chk("rst_init_done", init_done, 0);
    chk("rst_init_err", init_err, 0);
    chk("rst_err_index", err_index, 0);
    build();
    ref_cyc = cyc;
    Rst = 1'b0;
  endtask
  task automatic start_run();
    build();
    ref_cyc = cyc + 1;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask
  task automatic finish_run();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
    chk("init_done", init_done, exp_done);
    chk("init_err", init_err, exp_err);
    if (exp_err) chk("err_index", err_index, exp_eidx);
    chk("pending_writes", exp_q.size(), 0);
    repeat (15) @(negedge Clk);
    chk("still_idle", busy, 0);
  endtask
  task automatic base_table();
    rom[0] = {16'h3008, 8'h82};
    rom[1] = {16'h3103, 8'h03};
    rom[2] = {16'h3017, 8'hFF};
    rom[3] = {16'h300E, 8'h1A};
    foreach (nacks[i]) nacks[i] = 0;
  endtask
  initial begin
    int n;
    base_table();
    repeat (2) @(negedge Clk);
    do_reset();
    finish_run();
    rom[1] = {16'hFFFF, 8'h02};
    start_run();
    finish_run();
    base_table();
    nacks[1] = 2;
    start_run();
    finish_run();
    nacks[1] = 0;
    nacks[2] = 99;
    start_run();
    finish_run();
    nacks[2] = 0;
    start_run();
    repeat (5) @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    n = 0;
    while (!(wrreg_req && lut_index == 8'd1) && n < 500) begin
      @(negedge Clk);
      n++;
    end
    chk("reach_entry1_timeout", n < 500, 1);
    @(negedge Clk);
    do_reset();
    finish_run();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < TL; i++) begin
        if ($urandom_range(0, 4) == 0) rom[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
        else begin
          rom[i] = {16'($urandom), 8'($urandom)};
          if (rom[i][23:8] == 16'hFFFF) rom[i][23:8] = 16'h1234;
        end
        n = $urandom_range(0, 9);
        nacks[i] = n < 6 ? 0 : n < 9 ? n - 5 : 7;
      end
      start_run();
      finish_run();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog");
  end
endmodule
